rr_priority_encoder: RTL and testbench

RR_PRIORITY_ENCODER -- requirements
Module: rr_priority_encoder

---
 rtl/rr_priority_encoder.sv | 123 ++++++++++++
 tb/tb_rr_priority_encoder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rr_priority_encoder.sv
// Registered round-robin / fixed-priority encoder for a level request vector.
// Latency: request to out_valid is 1 cycle; grants can issue back-to-back, one per cycle.
// Backpressure: with out_ready low, the grant outputs hold stable and new requests wait.
module rr_priority_encoder #(
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = $clog2(INPUT_WIDTH),
  parameter int RR_MODE      = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [INPUT_WIDTH-1:0]  req_in,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [OUTPUT_WIDTH-1:0] out_code,
  output logic [INPUT_WIDTH-1:0]  grant_onehot,
  output logic                    out_multi
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [OUTPUT_WIDTH-1:0] ptr_q, ptr_hs, search_ptr;
  logic [INPUT_WIDTH-1:0]  eligible, pick_oh;
  logic [OUTPUT_WIDTH-1:0] pick_code;
  logic                    found, multi, hs, load, clear;
  int                      cnt;

  assign hs = out_valid & out_ready;

  // Wrap at the real request count, not at the code-space size.
  assign ptr_hs     = (out_code == OUTPUT_WIDTH'(INPUT_WIDTH - 1)) ? '0 : out_code + 1'b1;
  assign search_ptr = hs ? ptr_hs : ptr_q;
  assign eligible   = hs ? (req_in & ~grant_onehot) : req_in;

  always_comb begin
    found     = 1'b0;
    pick_code = '0;
    pick_oh   = '0;
    cnt       = 0;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      if (eligible[i]) cnt = cnt + 1;
    end
    if (RR_MODE != 0) begin
      for (int i = 0; i < INPUT_WIDTH; i++) begin
        if (!found && eligible[i] && (i >= int'(search_ptr))) begin
          found     = 1'b1;
          pick_code = OUTPUT_WIDTH'(i);
          pick_oh   = '0;
          pick_oh[i] = 1'b1;
        end
      end
      for (int i = 0; i < INPUT_WIDTH; i++) begin
        if (!found && eligible[i]) begin
          found     = 1'b1;
          pick_code = OUTPUT_WIDTH'(i);
          pick_oh   = '0;
          pick_oh[i] = 1'b1;
        end
      end
    end else begin
      // Ascending scan: the last set bit seen is the highest index.
      for (int i = 0; i < INPUT_WIDTH; i++) begin
        if (eligible[i]) begin
          found     = 1'b1;
          pick_code = OUTPUT_WIDTH'(i);
          pick_oh   = '0;
          pick_oh[i] = 1'b1;
        end
      end
    end
    multi = (cnt > 1);
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          load    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hs) begin
          if (found) begin
            load = 1'b1;
          end else begin
            clear   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      out_valid    <= 1'b0;
      out_code     <= '0;
      grant_onehot <= '0;
      out_multi    <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d == HOLD);
      if (hs) ptr_q <= ptr_hs;
      if (load) begin
        out_code     <= pick_code;
        grant_onehot <= pick_oh;
        out_multi    <= multi;
      end else if (clear) begin
        out_code     <= '0;
        grant_onehot <= '0;
        out_multi    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Scoreboard bench: three encoder configurations (W=8 round-robin, W=8 fixed, W=5 round-robin)
// share one clock/reset; expected grants are queued per instance and popped each cycle.
module tb_rr_priority_encoder;

  typedef struct {
    logic vld;
    int   code;
    logic multi;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [7:0] req_rr = '0, req_fx = '0;
  logic [4:0] req_w5 = '0;
  logic       rdy_rr = 1'b0, rdy_fx = 1'b0, rdy_w5 = 1'b0;

  logic       vld_rr, vld_fx, vld_w5;
  logic [2:0] code_rr, code_fx, code_w5;
  logic [7:0] oh_rr, oh_fx;
  logic [4:0] oh_w5;
  logic       multi_rr, multi_fx, multi_w5;

  exp_t q_rr[$], q_fx[$], q_w5[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  rr_priority_encoder #(.INPUT_WIDTH(8), .RR_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req_in(req_rr), .out_ready(rdy_rr),
    .out_valid(vld_rr), .out_code(code_rr), .grant_onehot(oh_rr), .out_multi(multi_rr));

  rr_priority_encoder #(.INPUT_WIDTH(8), .RR_MODE(0)) u_fx (
    .clk(clk), .rst_n(rst_n), .req_in(req_fx), .out_ready(rdy_fx),
    .out_valid(vld_fx), .out_code(code_fx), .grant_onehot(oh_fx), .out_multi(multi_fx));

  rr_priority_encoder #(.INPUT_WIDTH(5), .RR_MODE(1)) u_w5 (
    .clk(clk), .rst_n(rst_n), .req_in(req_w5), .out_ready(rdy_w5),
    .out_valid(vld_w5), .out_code(code_w5), .grant_onehot(oh_w5), .out_multi(multi_w5));

  task automatic chk_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic v, input int code,
                     input int oh, input logic m, input int w);
    chk_val({tag, ".vld"}, int'(v), int'(e.vld));
    chk_val({tag, ".onehot"}, oh, e.vld ? (1 << e.code) : 0);
    if (e.vld) begin
      chk_val({tag, ".code"}, code, e.code);
      chk_val({tag, ".multi"}, int'(m), int'(e.multi));
      chk_val({tag, ".range"}, int'(code < w), 1);
    end
  endtask

  task automatic push(input int inst, input logic v, input int code, input logic m);
    exp_t e;
    e.vld = v; e.code = code; e.multi = m;
    case (inst)
      0: q_rr.push_back(e);
      1: q_fx.push_back(e);
      default: q_w5.push_back(e);
    endcase
  endtask

  task automatic run(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (q_rr.size() > 0) begin
        e = q_rr.pop_front();
        cmp("rr", e, vld_rr, int'(code_rr), int'(oh_rr), multi_rr, 8);
      end
      if (q_fx.size() > 0) begin
        e = q_fx.pop_front();
        cmp("fx", e, vld_fx, int'(code_fx), int'(oh_fx), multi_fx, 8);
      end
      if (q_w5.size() > 0) begin
        e = q_w5.pop_front();
        cmp("w5", e, vld_w5, int'(code_w5), int'(oh_w5), multi_w5, 5);
      end
    end
  endtask

  task automatic chk_zero_all(input string tag);
    chk_val({tag, ".rr.vld"}, int'(vld_rr), 0);
    chk_val({tag, ".rr.code"}, int'(code_rr), 0);
    chk_val({tag, ".rr.oh"}, int'(oh_rr), 0);
    chk_val({tag, ".rr.multi"}, int'(multi_rr), 0);
    chk_val({tag, ".fx.vld"}, int'(vld_fx), 0);
    chk_val({tag, ".fx.oh"}, int'(oh_fx), 0);
    chk_val({tag, ".w5.vld"}, int'(vld_w5), 0);
    chk_val({tag, ".w5.oh"}, int'(oh_w5), 0);
  endtask

  // Assert reset midway between edges and check outputs clear before any edge.
  task automatic do_reset(input string tag);
    #4;
    rst_n = 1'b0;
    #1;
    chk_zero_all(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk_zero_all("reset");
    #4;
    rst_n = 1'b1;

    // Idle with no requests; out_ready high while idle is ignored
    rdy_rr = 1'b1; rdy_fx = 1'b1; rdy_w5 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push(0, 1'b0, 0, 1'b0); push(1, 1'b0, 0, 1'b0); push(2, 1'b0, 0, 1'b0);
    end
    run(2);

    // Round-robin W=8, fixed W=8, round-robin W=5, all streaming
    req_rr = 8'b1000_0101;
    req_fx = 8'b0010_0110;
    req_w5 = 5'b10001;
    push(0, 1'b1, 0, 1'b1); push(0, 1'b1, 2, 1'b1); push(0, 1'b1, 7, 1'b1);
    push(0, 1'b1, 0, 1'b1); push(0, 1'b1, 2, 1'b1);
    push(1, 1'b1, 5, 1'b1); push(1, 1'b1, 2, 1'b1); push(1, 1'b1, 5, 1'b1); push(1, 1'b1, 2, 1'b1);
    push(2, 1'b1, 0, 1'b1); push(2, 1'b1, 4, 1'b0); push(2, 1'b1, 0, 1'b0); push(2, 1'b1, 4, 1'b0);
    run(5);
    req_rr = '0; req_fx = '0; req_w5 = '0;
    push(0, 1'b0, 0, 1'b0); push(1, 1'b0, 0, 1'b0); push(2, 1'b0, 0, 1'b0);
    run(1);

    do_reset("reset_idle");

    // Backpressure: grant 4 held while the request moves to bit 0
    rdy_rr = 1'b0;
    req_rr = 8'h10;
    for (int i = 0; i < 5; i++) push(0, 1'b1, 4, 1'b0);
    run(2);
    req_rr = 8'h01;
    run(3);
    rdy_rr = 1'b1;
    push(0, 1'b1, 0, 1'b0);
    push(0, 1'b0, 0, 1'b0);
    run(2);

    // Single requester: valid toggles 1,0,1,0
    req_rr = 8'h08;
    push(0, 1'b1, 3, 1'b0); push(0, 1'b0, 0, 1'b0);
    push(0, 1'b1, 3, 1'b0); push(0, 1'b0, 0, 1'b0);
    run(4);

    // Reset mid-HOLD discards the grant and the pointer restarts at 0
    rdy_rr = 1'b0;
    req_rr = 8'b1000_0101;
    push(0, 1'b1, 7, 1'b1);
    run(1);
    do_reset("reset_hold");
    push(0, 1'b1, 0, 1'b1);
    push(0, 1'b1, 0, 1'b1);
    run(2);

    if (q_rr.size() + q_fx.size() + q_w5.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: %0d entries left unchecked", q_rr.size() + q_fx.size() + q_w5.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
